// File: rtl/rom_word_assembler_if.sv
// rom_word_assembler_if
//   Groups the FIFO read side, the configuration/status side and the
//   assembled-word stream of rom_word_assembler into one bundle.
//   master : the assembler (pops FIFO, produces words and status)
//   slave  : the environment (FIFO, configuration host, word consumer)
//   Signals:
//     fifo_data_out  FIFO head byte (first-word-fall-through)
//     fifo_empty     FIFO empty flag
//     fifo_data_pop  pop head byte this cycle
//     cfg_start      one-cycle transfer start pulse
//     cfg_abort      abandon current transfer
//     cfg_num_words  words to assemble, sampled on cfg_start
//     out_word       assembled word
//     out_valid      out_word valid
//     out_ready      consumer accepts out_word
//     out_last       final word of the transfer
//     busy           transfer in progress
//     done           one-cycle completion pulse
interface rom_word_assembler_if #(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int WORD_WIDTH      = 32,
  parameter int CNT_WIDTH       = 16
);
  logic [FIFO_DATA_WIDTH-1:0] fifo_data_out;
  logic                       fifo_empty;
  logic                       fifo_data_pop;
  logic                       cfg_start;
  logic                       cfg_abort;
  logic [CNT_WIDTH-1:0]       cfg_num_words;
  logic [WORD_WIDTH-1:0]      out_word;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;
  logic                       busy;
  logic                       done;

  modport master (
    input  fifo_data_out, fifo_empty, cfg_start, cfg_abort, cfg_num_words, out_ready,
    output fifo_data_pop, out_word, out_valid, out_last, busy, done
  );

  modport slave (
    output fifo_data_out, fifo_empty, cfg_start, cfg_abort, cfg_num_words, out_ready,
    input  fifo_data_pop, out_word, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/rom_word_assembler.sv
// rom_word_assembler
//   Pops bytes from a first-word-fall-through FIFO and packs them
//   little-endian into WORD_WIDTH words (first popped byte lands in the
//   least significant slot). A transfer of cfg_num_words words is started
//   by cfg_start; each finished word is offered on a valid/ready stream,
//   the last one flagged with out_last, and a one-cycle done pulse ends
//   the transfer. cfg_abort drops the transfer without a done pulse.
//   Ports:
//     clk      rising-edge clock
//     reset_n  synchronous, active-low reset
//     bus      rom_word_assembler_if.master (FIFO, config/status, word stream)
module rom_word_assembler #(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int WORD_WIDTH      = 32,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  rom_word_assembler_if.master   bus
);

  localparam int BPW  = WORD_WIDTH / FIFO_DATA_WIDTH;
  localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BPW - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    OUTPUT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [BC_W-1:0]        byte_cnt_r;
  logic [CNT_WIDTH-1:0]   word_cnt_r;
  logic [CNT_WIDTH-1:0]   num_words_r;
  logic [WORD_WIDTH-1:0]  word_r;
  logic                   busy_r;
  logic                   pop_s;
  logic                   valid_s;
  logic                   last_s;
  logic                   done_s;

  // Next-state decode and the decoded (non-registered) outputs.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    valid_s = 1'b0;
    done_s  = 1'b0;
    // Count is never zero outside IDLE/DONE, so the subtraction cannot wrap
    // while the result is used.
    last_s  = (word_cnt_r == (num_words_r - CNT_WIDTH'(1)));
    case (state_r)
      IDLE: begin
        if (bus.cfg_start) begin
          if (bus.cfg_num_words != '0) begin
            state_s = FILL;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        // Abort wins over everything, including a pending pop.
        if (bus.cfg_abort) begin
          state_s = IDLE;
        end else begin
          pop_s = !bus.fifo_empty;
          if (pop_s && (byte_cnt_r == BC_LAST)) begin
            state_s = OUTPUT;
          end else begin
            state_s = FILL;
          end
        end
      end
      OUTPUT: begin
        // out_valid is masked by abort so the consumer never sees an
        // acceptable word in the cycle the transfer is abandoned.
        if (bus.cfg_abort) begin
          state_s = IDLE;
        end else begin
          valid_s = 1'b1;
          if (bus.out_ready) begin
            if (last_s) begin
              state_s = DONE;
            end else begin
              state_s = FILL;
            end
          end else begin
            state_s = OUTPUT;
          end
        end
      end
      DONE: begin
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, counters and the word being assembled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      byte_cnt_r  <= '0;
      word_cnt_r  <= '0;
      num_words_r <= '0;
      word_r      <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == FILL) || (state_s == OUTPUT);
      case (state_r)
        IDLE: begin
          if (bus.cfg_start && (bus.cfg_num_words != '0)) begin
            num_words_r <= bus.cfg_num_words;
            word_cnt_r  <= '0;
            byte_cnt_r  <= '0;
            word_r      <= '0;
          end
        end
        FILL: begin
          if (bus.cfg_abort) begin
            byte_cnt_r <= '0;
            word_r     <= '0;
          end else if (pop_s) begin
            for (int k = 0; k < BPW; k++) begin
              if (byte_cnt_r == BC_W'(k)) begin
                word_r[k*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH] <= bus.fifo_data_out;
              end
            end
            byte_cnt_r <= (byte_cnt_r == BC_LAST) ? '0 : (byte_cnt_r + BC_W'(1));
          end
        end
        OUTPUT: begin
          if (bus.cfg_abort) begin
            byte_cnt_r <= '0;
            word_r     <= '0;
          end else if (bus.out_ready) begin
            word_cnt_r <= word_cnt_r + CNT_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.fifo_data_pop = pop_s;
  assign bus.out_valid     = valid_s;
  assign bus.out_last      = valid_s && last_s;
  assign bus.done          = done_s;
  assign bus.busy          = busy_r;
  assign bus.out_word      = word_r;

endmodule

// File: tb/tb_rom_word_assembler.sv
// tb_rom_word_assembler
//   Directed bench for rom_word_assembler (default parameters: bytes
//   packed into 32-bit words). A small FIFO model feeds the DUT; expected
//   words are written out by hand.
module tb_rom_word_assembler;

  logic clk = 1'b0;
  logic reset_n;

  rom_word_assembler_if #(.FIFO_DATA_WIDTH(8), .WORD_WIDTH(32), .CNT_WIDTH(16)) bus ();

  rom_word_assembler #(.FIFO_DATA_WIDTH(8), .WORD_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // FIFO model: bench writes mem/wr_ptr, pops advance rd_ptr.
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_count = 0;

  assign bus.fifo_empty    = (rd_ptr == wr_ptr);
  assign bus.fifo_data_out = mem[rd_ptr[7:0]];

  always @(posedge clk) begin
    if (bus.fifo_data_pop) begin
      rd_ptr    <= rd_ptr + 1;
      pop_count <= pop_count + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  int base;
  logic [31:0] held;

  initial begin
    reset_n           = 1'b0;
    bus.cfg_start     = 1'b0;
    bus.cfg_abort     = 1'b0;
    bus.cfg_num_words = 16'd0;
    bus.out_ready     = 1'b0;
    tick();
    tick();
    chk("rst_word",  bus.out_word, 64'h0);
    chk("rst_valid", bus.out_valid, 64'h0);
    chk("rst_last",  bus.out_last, 64'h0);
    chk("rst_pop",   bus.fifo_data_pop, 64'h0);
    chk("rst_busy",  bus.busy, 64'h0);
    chk("rst_done",  bus.done, 64'h0);
    reset_n = 1'b1;
    tick();

    // Two words, FIFO preloaded, consumer always ready.
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    base = pop_count;
    bus.out_ready     = 1'b1;
    bus.cfg_num_words = 16'd2;
    bus.cfg_start     = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    chk("t1_busy", bus.busy, 64'h1);
    chk("t1_pop",  bus.fifo_data_pop, 64'h1);
    repeat (4) tick();
    chk("t1_v0",    bus.out_valid, 64'h1);
    chk("t1_w0",    bus.out_word, 64'h44332211);
    chk("t1_last0", bus.out_last, 64'h0);
    chk("t1_nopop", bus.fifo_data_pop, 64'h0);
    tick();
    chk("t1_refill", bus.out_valid, 64'h0);
    repeat (4) tick();
    chk("t1_v1",    bus.out_valid, 64'h1);
    chk("t1_w1",    bus.out_word, 64'h88776655);
    chk("t1_last1", bus.out_last, 64'h1);
    tick();
    chk("t1_done",  bus.done, 64'h1);
    chk("t1_idle_busy", bus.busy, 64'h0);
    tick();
    chk("t1_done_off", bus.done, 64'h0);
    chk("t1_pops", 64'(pop_count - base), 64'd8);

    // One word with the FIFO running dry after two bytes, then back-pressure.
    push(8'hA1);
    push(8'hB2);
    bus.cfg_num_words = 16'd1;
    bus.cfg_start     = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_pop",   bus.fifo_data_pop, 64'h0);
      chk("t2_stall_busy",  bus.busy, 64'h1);
      chk("t2_stall_valid", bus.out_valid, 64'h0);
      tick();
    end
    bus.out_ready = 1'b0;
    push(8'hC3);
    push(8'hD4);
    push(8'hE5);
    #1;
    chk("t2_resume_pop", bus.fifo_data_pop, 64'h1);
    tick();
    tick();
    chk("t2_word", bus.out_word, 64'hD4C3B2A1);
    chk("t2_last", bus.out_last, 64'h1);
    base = pop_count;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_hold_valid", bus.out_valid, 64'h1);
      chk("t3_hold_word",  bus.out_word, 64'hD4C3B2A1);
      chk("t3_hold_pop",   bus.fifo_data_pop, 64'h0);
    end
    chk("t3_hold_pops", 64'(pop_count - base), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("t3_done", bus.done, 64'h1);
    tick();
    wr_ptr = rd_ptr;

    // Zero-length transfer: straight to DONE, no pops, never busy.
    push(8'h5A);
    base = pop_count;
    bus.cfg_num_words = 16'd0;
    bus.cfg_start     = 1'b1;
    #1;
    chk("t4_pop_idle", bus.fifo_data_pop, 64'h0);
    tick();
    bus.cfg_start = 1'b0;
    chk("t4_done", bus.done, 64'h1);
    chk("t4_busy", bus.busy, 64'h0);
    tick();
    chk("t4_done_off", bus.done, 64'h0);
    chk("t4_busy2",    bus.busy, 64'h0);
    chk("t4_pops", 64'(pop_count - base), 64'd0);
    wr_ptr = rd_ptr;

    // Abort after the third byte; stale bytes must not leak into the next word.
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    bus.cfg_num_words = 16'd1;
    bus.cfg_start     = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    repeat (3) tick();
    bus.cfg_abort = 1'b1;
    #1;
    chk("t5_abort_pop", bus.fifo_data_pop, 64'h0);
    tick();
    bus.cfg_abort = 1'b0;
    chk("t5_abort_busy",  bus.busy, 64'h0);
    chk("t5_abort_valid", bus.out_valid, 64'h0);
    chk("t5_abort_done",  bus.done, 64'h0);
    tick();
    chk("t5_no_done", bus.done, 64'h0);
    wr_ptr = rd_ptr;
    push(8'h55);
    push(8'h66);
    push(8'h77);
    push(8'h88);
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    repeat (4) tick();
    chk("t5_word",  bus.out_word, 64'h88776655);
    chk("t5_valid", bus.out_valid, 64'h1);
    tick();
    chk("t5_done", bus.done, 64'h1);
    tick();

    // Start ignored while busy, then reset in OUTPUT.
    push(8'h9A);
    push(8'hBC);
    push(8'hDE);
    push(8'hF0);
    bus.out_ready     = 1'b0;
    bus.cfg_num_words = 16'd1;
    bus.cfg_start     = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    repeat (4) tick();
    chk("t6_valid", bus.out_valid, 64'h1);
    held = bus.out_word;
    chk("t6_word", bus.out_word, 64'hF0DEBC9A);
    bus.cfg_num_words = 16'd5;
    bus.cfg_start     = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    chk("t6_ign_valid", bus.out_valid, 64'h1);
    chk("t6_ign_word",  bus.out_word, 64'(held));
    chk("t6_ign_last",  bus.out_last, 64'h1);
    reset_n = 1'b0;
    tick();
    chk("t6_rst_word",  bus.out_word, 64'h0);
    chk("t6_rst_valid", bus.out_valid, 64'h0);
    chk("t6_rst_last",  bus.out_last, 64'h0);
    chk("t6_rst_busy",  bus.busy, 64'h0);
    chk("t6_rst_done",  bus.done, 64'h0);
    chk("t6_rst_pop",   bus.fifo_data_pop, 64'h0);
    reset_n = 1'b1;
    tick();
    chk("t6_post_done", bus.done, 64'h0);
    chk("t6_post_busy", bus.busy, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
